// File: rtl/reg_read_bank.sv
// Register bank with one write port and two registered read ports, entry 0 hardwired to zero.
// Optional macro REG_BYPASS_EN forwards same-edge write data to a colliding read.
module reg_read_bank #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [SIZE-1:0]  wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    input  logic [SIZE-1:0]  rd_addr_a,
    input  logic [SIZE-1:0]  rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_valid
);

    localparam int DEPTH = 2 ** SIZE;

`ifdef REG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_live;
    logic [WIDTH-1:0] word_a;
    logic [WIDTH-1:0] word_b;

    // Entry 0 is cleared by reset and never written, so it always reads zero.
    assign wr_live = we && (wr_addr != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_live) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        word_a = mem[rd_addr_a];
        word_b = mem[rd_addr_b];
        if (BYPASS && wr_live && (wr_addr == rd_addr_a)) begin
            word_a = wr_data;
        end
        if (BYPASS && wr_live && (wr_addr == rd_addr_b)) begin
            word_b = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data_a <= word_a;
                rd_data_b <= word_b;
            end
        end
    end

endmodule

// File: tb/tb_reg_read_bank.sv
// Scoreboard bench for reg_read_bank: default 32x32 instance plus a 16-bit, 8-entry instance.
// Expected bypass behaviour follows REG_BYPASS_EN as defined for the build.
module tb_reg_read_bank;

`ifdef REG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_req;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        rd_valid;

    logic        s_we;
    logic [2:0]  s_wr_addr;
    logic [15:0] s_wr_data;
    logic        s_rd_req;
    logic [2:0]  s_rd_addr_a;
    logic [2:0]  s_rd_addr_b;
    logic [15:0] s_rd_data_a;
    logic [15:0] s_rd_data_b;
    logic        s_rd_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mdl [32];
    logic [15:0] smdl [8];
    logic [31:0] sb_a [$];
    logic [31:0] sb_b [$];
    logic [31:0] last_a;
    logic [31:0] last_b;

    reg_read_bank dut (
        .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid)
    );

    reg_read_bank #(.WIDTH(16), .SIZE(3)) dut_s (
        .clk(clk), .reset(reset), .we(s_we), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .rd_req(s_rd_req), .rd_addr_a(s_rd_addr_a), .rd_addr_b(s_rd_addr_b),
        .rd_data_a(s_rd_data_a), .rd_data_b(s_rd_data_b), .rd_valid(s_rd_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic w, input logic [4:0] wa,
                                             input logic [31:0] wd, input logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
        if (BYPASS && w && (wa == ra)) return wd;
        return mdl[ra];
    endfunction

    // One clock of stimulus on the 32-bit instance; expectations go to the scoreboard.
    task automatic cyc(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rq, input logic [4:0] ra, input logic [4:0] rb);
        we = w; wr_addr = wa; wr_data = wd;
        rd_req = rq; rd_addr_a = ra; rd_addr_b = rb;
        if (rq) begin
            sb_a.push_back(model_rd(w, wa, wd, ra));
            sb_b.push_back(model_rd(w, wa, wd, rb));
        end
        if (w && wa != 5'd0) mdl[wa] = wd;
        @(posedge clk);
        #1;
        check("rd_valid", {31'd0, rd_valid}, {31'd0, rq});
        if (rd_valid) begin
            if (sb_a.size() == 0) begin
                check("sb_empty", 32'd0, 32'd1);
            end else begin
                last_a = sb_a.pop_front();
                last_b = sb_b.pop_front();
                check("rd_data_a", rd_data_a, last_a);
                check("rd_data_b", rd_data_b, last_b);
            end
        end else begin
            check("hold_a", rd_data_a, last_a);
            check("hold_b", rd_data_b, last_b);
        end
        we = 1'b0; rd_req = 1'b0;
    endtask

    task automatic scyc(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                        input logic rq, input logic [2:0] ra, input logic [2:0] rb);
        logic [15:0] ea;
        logic [15:0] eb;
        s_we = w; s_wr_addr = wa; s_wr_data = wd;
        s_rd_req = rq; s_rd_addr_a = ra; s_rd_addr_b = rb;
        ea = (ra == 3'd0) ? 16'h0 : ((BYPASS && w && wa == ra) ? wd : smdl[ra]);
        eb = (rb == 3'd0) ? 16'h0 : ((BYPASS && w && wa == rb) ? wd : smdl[rb]);
        if (w && wa != 3'd0) smdl[wa] = wd;
        @(posedge clk);
        #1;
        check("s_rd_valid", {31'd0, s_rd_valid}, {31'd0, rq});
        if (rq) begin
            check("s_rd_data_a", {16'd0, s_rd_data_a}, {16'd0, ea});
            check("s_rd_data_b", {16'd0, s_rd_data_b}, {16'd0, eb});
        end
        s_we = 1'b0; s_rd_req = 1'b0;
    endtask

    initial begin
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  wa;
        logic [31:0] wd;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        for (int i = 0; i < 8; i++) smdl[i] = 16'h0;
        last_a = 32'h0; last_b = 32'h0;
        reset = 1'b0;
        we = 1'b0; wr_addr = '0; wr_data = '0; rd_req = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        s_we = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_rd_req = 1'b0;
        s_rd_addr_a = '0; s_rd_addr_b = '0;
        #1;
        check("rst_data_a", rd_data_a, 32'h0);
        check("rst_data_b", rd_data_b, 32'h0);
        check("rst_valid", {31'd0, rd_valid}, 32'h0);
        #20;
        reset = 1'b1;

        // read after reset
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0);
        // write then dual read of the same address; write to entry 0 is dropped
        cyc(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7);
        cyc(1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 5'd0);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd7);
        // same-edge write/read collision, then readback
        cyc(1'b1, 5'd9, 32'h00000011, 1'b0, 5'd0, 5'd0);
        cyc(1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd9, 5'd7);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9);
        // collision on port B only, different-address write on A
        cyc(1'b1, 5'd10, 32'h0BADF00D, 1'b1, 5'd9, 5'd10);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd9);
        // back-to-back reads then idle hold
        cyc(1'b1, 5'd1, 32'h10, 1'b0, 5'd0, 5'd0);
        cyc(1'b1, 5'd2, 32'h20, 1'b0, 5'd0, 5'd0);
        cyc(1'b1, 5'd3, 32'h30, 1'b0, 5'd0, 5'd0);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd3);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd2);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd1);
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        cyc(1'b1, 5'd3, 32'h77, 1'b0, 5'd4, 5'd4);
        // top address
        cyc(1'b1, 5'd31, 32'hCAFE0031, 1'b1, 5'd31, 5'd30);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 5'd0);

        // random traffic
        for (int n = 0; n < 200; n++) begin
            wa = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rb = 5'($urandom_range(0, 31));
            wd = $urandom;
            cyc(1'($urandom_range(0, 1)), wa, wd, 1'($urandom_range(0, 1)), ra, rb);
        end

        // reset asserted mid-cycle while a read is being presented
        cyc(1'b1, 5'd5, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5);
        rd_req = 1'b1; rd_addr_a = 5'd5; rd_addr_b = 5'd5;
        we = 1'b1; wr_addr = 5'd6; wr_data = 32'h66666666;
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_data_a", rd_data_a, 32'h0);
        check("mid_rst_data_b", rd_data_b, 32'h0);
        check("mid_rst_valid", {31'd0, rd_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("in_rst_valid", {31'd0, rd_valid}, 32'h0);
        check("in_rst_data_a", rd_data_a, 32'h0);
        rd_req = 1'b0; we = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        for (int i = 0; i < 8; i++) smdl[i] = 16'h0;
        sb_a.delete(); sb_b.delete();
        last_a = 32'h0; last_b = 32'h0;
        @(posedge clk);
        #1;
        check("post_rst_valid", {31'd0, rd_valid}, 32'h0);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd6);
        cyc(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 5'd0);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4);

        // 16-bit, 8-entry instance: fill every entry, read all back, then collide
        for (int i = 0; i < 8; i++) begin
            scyc(1'b1, 3'(i), (i == 7) ? 16'hBEEF : 16'(16'h1000 + i * 16'h0111), 1'b0, 3'd0, 3'd0);
        end
        for (int i = 0; i < 8; i++) begin
            scyc(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 3'(7 - i));
        end
        scyc(1'b1, 3'd2, 16'h5A5A, 1'b1, 3'd2, 3'd7);
        scyc(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd0);

        check("sb_drained", sb_a.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_read_bank.md
REG_READ_BANK -- requirements
Module: reg_read_bank

Interface
- REQ-001: WIDTH SHALL be a parameter, default 32, giving the data word width in bits.
- REQ-002: SIZE SHALL be a parameter, default 5, giving the address width; storage depth SHALL be 2**SIZE words.
- REQ-003: clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
- REQ-004: reset  input  1  SHALL be the asynchronous, active-low reset.
- REQ-005: we  input  1  SHALL be the write enable.
- REQ-006: wr_addr  input  SIZE  SHALL be the write address.
- REQ-007: wr_data  input  WIDTH  SHALL be the write data.
- REQ-008: rd_req  input  1  SHALL be the read request, sampled on each rising edge.
- REQ-009: rd_addr_a  input  SIZE  SHALL be the port A read address.
- REQ-010: rd_addr_b  input  SIZE  SHALL be the port B read address.
- REQ-011: rd_data_a  output  WIDTH  SHALL be the registered port A read data.
- REQ-012: rd_data_b  output  WIDTH  SHALL be the registered port B read data.
- REQ-013: rd_valid  output  1  SHALL be high for exactly the cycle after each accepted read.

Function
- REQ-014: The block SHALL hold 2**SIZE words of WIDTH bits.
- REQ-015: Writes: when we=1 at a rising edge and wr_addr!=0, the entry wr_addr SHALL take wr_data.
- REQ-016: Writes with wr_addr=0 SHALL be discarded; entry 0 SHALL read as all-zero at all times.
- REQ-017: Reads: when rd_req=1 at a rising edge, rd_data_a/rd_data_b SHALL load the entries at rd_addr_a/rd_addr_b, and rd_valid SHALL be 1 in the following cycle (latency 1).
- REQ-018: When rd_req=0 at a rising edge, rd_data_a/rd_data_b SHALL hold their previous values and rd_valid SHALL be 0.
- REQ-019: Back-to-back reads (rd_req held high) SHALL each complete at one per cycle, with rd_valid held high.
- REQ-020: rd_addr_a = rd_addr_b SHALL return identical data on both ports.
- REQ-021: A same-cycle write and read of the same nonzero address SHALL follow the bypass rule of REQ-027/REQ-028; different addresses SHALL not interact.
- REQ-022: Address decode SHALL cover the full SIZE-bit range, so no read address is out of range.

Reset
- REQ-023: reset=0 SHALL immediately clear every storage entry, rd_data_a, rd_data_b and rd_valid to 0, independent of clk.
- REQ-024: While reset=0, writes and reads SHALL be ignored.
- REQ-025: A read accepted in the cycle reset asserts SHALL be abandoned; rd_valid SHALL stay 0 after release until a new rd_req is sampled.
- REQ-026: The first rising edge after reset returns to 1 SHALL operate normally.

Configuration
- REQ-027: With macro REG_BYPASS_EN defined, a read sampled on the same edge as a write to the same nonzero address SHALL return the new wr_data on that port.
- REQ-028: Without REG_BYPASS_EN, that read SHALL return the pre-write stored value; the new value SHALL be visible from the next read onward.

Verification
- REQ-029: Reset, then read A=3, B=0 -> rd_data_a=0, rd_data_b=0, rd_valid=1 one cycle later.
- REQ-030: Write 0xDEADBEEF to 7, then read A=7, B=7 -> both ports 0xDEADBEEF; write 0x1234 to 0, then read A=0 -> 0.
- REQ-031: Same edge: write 0xA5A5A5A5 to 9 and read A=9 (old value 0x11) -> 0xA5A5A5A5 with REG_BYPASS_EN, 0x11 without; next read -> 0xA5A5A5A5.
- REQ-032: Three consecutive rd_req cycles at addresses 1, 2, 3 (holding 0x10, 0x20, 0x30) -> rd_valid high 3 cycles, data 0x10, 0x20, 0x30 in order; rd_req=0 -> rd_data holds 0x30, rd_valid=0.
- REQ-033: Assert reset mid-clock during a read of 0xFFFFFFFF -> outputs 0 immediately, rd_valid 0 after release, a subsequent read of that address -> 0.
- REQ-034: With WIDTH=16, SIZE=3: write 0xBEEF to 7 and read -> 0xBEEF; all 8 entries are writable and readable except entry 0.
